// File: rtl/hub75_panel_rx.sv
// HUB75 panel receiver: rebuilds latched double-rows, streams pixels, measures OE on-time; latch acts 3 cycles after the pin edge.
// Pixel stream holds all outputs while PIX_READY is low; a latch arriving mid-stream flags OVR_ERR and restarts the stream.
module hub75_panel_rx #(
  parameter int WIDTH    = 32,
  parameter int ROW_BITS = 4,
  parameter int ON_BITS  = 16,
  localparam int COL_BITS = $clog2(WIDTH),
  localparam int CNT_BITS = $clog2(WIDTH + 2)
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  input  logic                R0,
  input  logic                G0,
  input  logic                B0,
  input  logic                R1,
  input  logic                G1,
  input  logic                B1,
  input  logic                RA,
  input  logic                RB,
  input  logic                RC,
  input  logic                RD,
  input  logic                CLK_O,
  input  logic                LATCH,
  input  logic                OE,
  output logic                PIX_VALID,
  input  logic                PIX_READY,
  output logic [ROW_BITS:0]   PIX_ROW,
  output logic [COL_BITS-1:0] PIX_COL,
  output logic [2:0]          PIX_RGB,
  output logic [ON_BITS-1:0]  ON_TIME,
  output logic                ON_VALID,
  output logic                LEN_ERR,
  output logic                OVR_ERR
);

  typedef enum logic [1:0] {IDLE, UPPER, LOWER} state_t;

  // Bit order: {OE, LATCH, CLK_O, RD, RC, RB, RA, R0, G0, B0, R1, G1, B1}
  localparam logic [12:0] SYNC_RST = 13'h1000;

  logic [12:0] sync1, sync2;
  logic        clk_d3, lat_d3;
  logic        clk_rise, lat_rise, oe_low;
  logic [5:0]  data6;
  logic [3:0]  addr4;

  logic [WIDTH-1:0][5:0] sh_buf, sh_next, disp_buf;
  logic [ROW_BITS-1:0]   row_q;
  logic [CNT_BITS-1:0]   shift_cnt, cnt_next;
  logic [ON_BITS-1:0]    on_cnt;

  state_t              state, state_nx;
  logic [COL_BITS-1:0] col, col_nx;
  logic                accept;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      sync1  <= SYNC_RST;
      sync2  <= SYNC_RST;
      clk_d3 <= 1'b0;
      lat_d3 <= 1'b0;
    end else begin
      sync1  <= {OE, LATCH, CLK_O, RD, RC, RB, RA, R0, G0, B0, R1, G1, B1};
      sync2  <= sync1;
      clk_d3 <= sync2[10];
      lat_d3 <= sync2[11];
    end
  end

  assign data6    = sync2[5:0];
  assign addr4    = sync2[9:6];
  assign clk_rise = sync2[10] & ~clk_d3;
  assign lat_rise = sync2[11] & ~lat_d3;
  assign oe_low   = ~sync2[12];

  // Newest bit enters column 0, so the first-shifted bit ends at WIDTH-1.
  always_comb begin
    sh_next  = clk_rise ? {sh_buf[WIDTH-2:0], data6} : sh_buf;
    cnt_next = shift_cnt;
    if (clk_rise && shift_cnt != CNT_BITS'(WIDTH + 1))
      cnt_next = shift_cnt + 1'b1;
  end

  always_ff @(posedge CLK_I) begin
    sh_buf <= sh_next;
    if (lat_rise) begin
      disp_buf <= sh_next;
      row_q    <= addr4[ROW_BITS-1:0];
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      shift_cnt <= '0;
      on_cnt    <= '0;
      ON_TIME   <= '0;
      ON_VALID  <= 1'b0;
      LEN_ERR   <= 1'b0;
      OVR_ERR   <= 1'b0;
    end else begin
      ON_VALID <= lat_rise;
      if (lat_rise) begin
        if (cnt_next != CNT_BITS'(WIDTH)) LEN_ERR <= 1'b1;
        if (state != IDLE) OVR_ERR <= 1'b1;
        shift_cnt <= '0;
        ON_TIME   <= on_cnt;
        on_cnt    <= oe_low ? ON_BITS'(1) : '0;
      end else begin
        shift_cnt <= cnt_next;
        if (oe_low && on_cnt != '1) on_cnt <= on_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state <= IDLE;
      col   <= '0;
    end else begin
      state <= state_nx;
      col   <= col_nx;
    end
  end

  assign accept = PIX_VALID & PIX_READY;

  always_comb begin
    state_nx = state;
    col_nx   = col;
    if (lat_rise) begin
      state_nx = UPPER;
      col_nx   = '0;
    end else if (state != IDLE && accept) begin
      if (col == COL_BITS'(WIDTH - 1)) begin
        col_nx   = '0;
        state_nx = (state == UPPER) ? LOWER : IDLE;
      end else begin
        col_nx = col + 1'b1;
      end
    end
  end

  always_comb begin
    PIX_VALID = 1'b0;
    PIX_ROW   = '0;
    PIX_COL   = col;
    PIX_RGB   = 3'b000;
    case (state)
      UPPER: begin
        PIX_VALID = 1'b1;
        PIX_ROW   = {1'b0, row_q};
        PIX_RGB   = disp_buf[col][5:3];
      end
      LOWER: begin
        PIX_VALID = 1'b1;
        PIX_ROW   = {1'b1, row_q};
        PIX_RGB   = disp_buf[col][2:0];
      end
      default: ;
    endcase
  end

endmodule
